// File: rtl/mem_cmd_ctrl.sv
// Valid/ready command and response front end for interleaved_memory.
// Rejects misaligned accesses, registers memory-side outputs, returns one in-order response per command.

package mem_cfg_pkg;
    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_width_t;
endpackage

module mem_cmd_ctrl
    import mem_cfg_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 1,
    parameter int RSP_DEPTH    = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  mem_width_t        cmd_width_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_we_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output mem_width_t        mem_width_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam int TAG_N = READ_LATENCY + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RSP_DEPTH);
    localparam logic [SUM_W-1:0] DEPTH_S  = SUM_W'(RSP_DEPTH);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
            $error("mem_cmd_ctrl: READ_LATENCY must be in 1..3");
        end
        if (RSP_DEPTH < READ_LATENCY + 2) begin : g_bad_depth
            $error("mem_cmd_ctrl: RSP_DEPTH must be >= READ_LATENCY+2");
        end
    endgenerate

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic        err;
    } rsp_entry_t;

    logic              run_q, run_d;
    logic              accept;
    logic              misaligned;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    mem_width_t        mem_width_q, mem_width_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_data_q, mem_data_d;
    logic [TAG_N-1:0]  tag_vld_q, tag_vld_d;
    logic [TAG_N-1:0]  tag_we_q, tag_we_d;
    logic [TAG_N-1:0]  tag_err_q, tag_err_d;
    rsp_entry_t        fifo_mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic [SUM_W-1:0]  inflight_cnt;
    logic [SUM_W-1:0]  occupancy;
    logic              push, push_ok, pop;
    logic              fifo_empty, fifo_full;
    rsp_entry_t        push_entry, head_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        case (cmd_width_i)
            HALF:    misaligned = cmd_addr_i[0];
            WORD:    misaligned = |cmd_addr_i[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Every tag stage and every FIFO entry owns one response slot, so admission
    // against their sum keeps the FIFO from ever overflowing.
    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < TAG_N; i++) begin
            inflight_cnt = inflight_cnt + SUM_W'(tag_vld_q[i]);
        end
    end

    assign occupancy   = SUM_W'(fifo_cnt_q) + inflight_cnt;
    assign cmd_ready_o = run_q && (occupancy < DEPTH_S);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign run_d       = 1'b1;

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_width_d = mem_width_q;
        mem_data_d  = mem_data_q;
        mem_we_d    = 1'b0;
        if (accept && !misaligned) begin
            mem_addr_d  = cmd_addr_i;
            mem_width_d = cmd_width_i;
            mem_data_d  = cmd_data_i;
            mem_we_d    = cmd_we_i;
        end
    end

    always_comb begin
        tag_vld_d = {tag_vld_q[TAG_N-2:0], accept};
        tag_we_d  = {tag_we_q[TAG_N-2:0], cmd_we_i};
        tag_err_d = {tag_err_q[TAG_N-2:0], misaligned};
    end

    // The tag leaves the pipe in the cycle the memory presents this command's read data.
    always_comb begin
        push            = tag_vld_q[TAG_N-1];
        push_entry.we   = tag_we_q[TAG_N-1];
        push_entry.err  = tag_err_q[TAG_N-1];
        push_entry.data = (tag_we_q[TAG_N-1] || tag_err_q[TAG_N-1]) ? 32'd0 : mem_data_i;
    end

    always_comb begin
        fifo_empty  = (fifo_cnt_q == '0);
        fifo_full   = (fifo_cnt_q == CNT_FULL);
        head_entry  = fifo_mem_q[rd_ptr_q];
        rsp_valid_o = !fifo_empty;
        rsp_data_o  = fifo_empty ? 32'd0 : head_entry.data;
        rsp_we_o    = !fifo_empty && head_entry.we;
        rsp_err_o   = !fifo_empty && head_entry.err;
        pop         = !fifo_empty && rsp_ready_i;
        push_ok     = push && (!fifo_full || pop);
    end

    always_comb begin
        wr_ptr_d   = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push_ok && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (pop && !push_ok) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_width_q <= BYTE;
            mem_we_q    <= 1'b0;
            mem_data_q  <= '0;
            tag_vld_q   <= '0;
            tag_we_q    <= '0;
            tag_err_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            run_q       <= run_d;
            mem_addr_q  <= mem_addr_d;
            mem_width_q <= mem_width_d;
            mem_we_q    <= mem_we_d;
            mem_data_q  <= mem_data_d;
            tag_vld_q   <= tag_vld_d;
            tag_we_q    <= tag_we_d;
            tag_err_q   <= tag_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign mem_width_o = mem_width_q;
    assign mem_we_o    = mem_we_q;
    assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_mem_cmd_ctrl.sv
// Scoreboard bench for mem_cmd_ctrl driving a behavioural byte-lane memory with one cycle read latency.
module tb_mem_cmd_ctrl;
    import mem_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    mem_width_t  cmd_width = BYTE;
    logic [9:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;
    logic        rsp_we;
    logic        rsp_err;
    logic [9:0]  mem_addr;
    mem_width_t  mem_width;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    typedef struct {
        logic [31:0] d;
        logic        we;
        logic        err;
        int          acc;
        bit          lchk;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   we_cycles = 0;
    int   rsp_idx = 0;
    logic [7:0] mem_b [1024];

    mem_cmd_ctrl #(.ADDR_W(10), .READ_LATENCY(1), .RSP_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_width_i(cmd_width), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rsp_we_o(rsp_we), .rsp_err_o(rsp_err),
        .mem_addr_o(mem_addr), .mem_width_o(mem_width), .mem_we_o(mem_we),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Little-endian byte memory: registered read, write on the edge that sees write enable.
    initial begin
        logic [9:0] a;
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'(i) ^ 8'hC3;
        forever begin
            @(posedge clk);
            a = mem_addr;
            case (mem_width)
                HALF:    mem_rdata <= {16'h0, mem_b[a + 10'd1], mem_b[a]};
                WORD:    mem_rdata <= {mem_b[a + 10'd3], mem_b[a + 10'd2], mem_b[a + 10'd1], mem_b[a]};
                default: mem_rdata <= {24'h0, mem_b[a]};
            endcase
            if (mem_we) begin
                mem_b[a] = mem_wdata[7:0];
                if (mem_width != BYTE) mem_b[a + 10'd1] = mem_wdata[15:8];
                if (mem_width == WORD) begin
                    mem_b[a + 10'd2] = mem_wdata[23:16];
                    mem_b[a + 10'd3] = mem_wdata[31:24];
                end
            end
        end
    end

    function automatic logic [31:0] pat(input logic [9:0] a);
        logic [7:0] b;
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            b = (a[7:0] + 8'(k)) ^ 8'hC3;
            w[8*k +: 8] = b;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic issue(input logic we, input mem_width_t w, input logic [9:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_err, input bit lchk);
        rsp_t r;
        int waited;
        waited = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_width = w; cmd_addr = a; cmd_data = d;
        @(negedge clk);
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: addr %h not accepted after %0d cycles, required acceptance", a, waited);
        end else begin
            r.d = exp_d; r.we = we; r.err = exp_err; r.acc = cyc + 1; r.lchk = lchk;
            exp_q.push_back(r);
            acc_cnt++;
            $display("cmd we=%b width=%0d addr=%h data=%h", we, w, a, d);
            if (lchk) chk("accept_no_stall", waited, 0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
        #1;
    endtask

    // Response monitor: pops the scoreboard on every handshake.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (mem_we) we_cycles++;
            if (rsp_valid && rsp_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rsp: got data=%h we=%b err=%b, required no response", rsp_data, rsp_we, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_data !== e.d || rsp_we !== e.we || rsp_err !== e.err || (e.lchk && cyc != e.acc + 2)) begin
                        bad++;
                        $display("FAIL rsp[%0d]: got data=%h we=%b err=%b cyc=%0d, required data=%h we=%b err=%b cyc=%0d",
                                 rsp_idx, rsp_data, rsp_we, rsp_err, cyc, e.d, e.we, e.err, e.lchk ? e.acc + 2 : cyc);
                    end else begin
                        $display("rsp[%0d] data=%h we=%b err=%b", rsp_idx, rsp_data, rsp_we, rsp_err);
                    end
                end
                rsp_idx++;
            end
        end
    end

    initial begin
        int acc_base;
        logic [9:0] a;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cmd_ready", cmd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_width", {30'd0, mem_width}, {30'd0, BYTE});
        rst_ni = 1'b1;
        #1;
        chk("ready_before_edge", cmd_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", cmd_ready, 1);

        // WORD write then WORD read of the same location
        issue(1'b1, WORD, 10'h004, 32'h0DEFACED, 32'h0, 1'b0, 1'b1);
        chk("wr_mem_we_high", mem_we, 1);
        chk("wr_mem_addr", {22'd0, mem_addr}, 32'h004);
        chk("wr_mem_width", {30'd0, mem_width}, {30'd0, WORD});
        chk("wr_mem_data", mem_wdata, 32'h0DEFACED);
        issue(1'b0, WORD, 10'h004, 32'h0, 32'h0DEFACED, 1'b0, 1'b1);
        chk("rd_mem_we_low", mem_we, 0);

        // Byte lane update
        issue(1'b1, BYTE, 10'h005, 32'h000000A7, 32'h0, 1'b0, 1'b1);
        chk("bw_mem_data", mem_wdata, 32'h000000A7);
        issue(1'b0, WORD, 10'h004, 32'h0, 32'h0DEFA7ED, 1'b0, 1'b1);

        // Misaligned accesses leave the memory port untouched
        issue(1'b0, HALF, 10'h003, 32'h0, 32'h0, 1'b1, 1'b1);
        chk("mis_half_mem_we", mem_we, 0);
        chk("mis_half_mem_addr", {22'd0, mem_addr}, 32'h004);
        issue(1'b1, WORD, 10'h002, 32'h12345678, 32'h0, 1'b1, 1'b1);
        chk("mis_word_mem_we", mem_we, 0);
        chk("mis_word_mem_addr", {22'd0, mem_addr}, 32'h004);
        chk("mis_word_mem_width", {30'd0, mem_width}, {30'd0, WORD});
        issue(1'b0, WORD, 10'h000, 32'h0, pat(10'h000), 1'b0, 1'b1);
        issue(1'b0, WORD, 10'h004, 32'h0, 32'h0DEFA7ED, 1'b0, 1'b1);
        drain();

        // Backpressure: only RSP_DEPTH commands fit while responses are held
        rsp_ready = 1'b0;
        acc_base = acc_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    a = 10'(32'h020 + 4 * i);
                    issue(1'b0, WORD, a, 32'h0, pat(a), 1'b0, 1'b0);
                end
            end
            begin
                repeat (12) @(negedge clk);
                chk("bp_accepts", acc_cnt - acc_base, 4);
                chk("bp_cmd_ready_low", cmd_ready, 0);
                chk("bp_head_valid", rsp_valid, 1);
                chk("bp_head_data", rsp_data, pat(10'h020));
                @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();
        chk("bp_all_accepted", acc_cnt - acc_base, 8);

        // Streaming reads, one accept per cycle, fixed latency
        for (int i = 0; i < 16; i++) begin
            a = 10'(4 * i);
            issue(1'b0, WORD, a, 32'h0, (a == 10'h004) ? 32'h0DEFA7ED : pat(a), 1'b0, 1'b1);
        end
        drain();

        // Reset with three commands in flight
        issue(1'b0, WORD, 10'h008, 32'h0, pat(10'h008), 1'b0, 1'b1);
        issue(1'b0, WORD, 10'h00C, 32'h0, pat(10'h00C), 1'b0, 1'b1);
        issue(1'b1, WORD, 10'h010, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1);
        rst_ni = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_mem_addr", {22'd0, mem_addr}, 32'h0);
        chk("mid_rst_mem_data", mem_wdata, 32'h0);
        chk("mid_rst_mem_width", {30'd0, mem_width}, {30'd0, BYTE});
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_rsp_we", rsp_we, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, WORD, 10'h010, 32'h0, pat(10'h010), 1'b0, 1'b1);
        drain();
        repeat (10) @(posedge clk);
        #1;

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("mem_we_cycles", we_cycles, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
